p_output_stage: RTL
===================

P_OUTPUT_STAGE -- requirements
Module: p_output_stage

Interface
REQ-001 SHALL have parameter PREG, default 1, meaning 1 = registered P path and 0 = combinational P path.
REQ-002 SHALL have parameter CARRYOUTREG, default 1, meaning 1 = registered carry path and 0 = combinational carry path.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rstp  input  1  synchronous clear, active-high.
REQ-006 SHALL have port cep  input  1  P-path clock enable.
REQ-007 SHALL have port cecarry  input  1  carry-path clock enable.
REQ-008 SHALL have port in_valid  input  1  post-adder result valid.
REQ-009 SHALL have port post_out  input  48  post-adder sum/difference.
REQ-010 SHALL have port post_cout  input  1  post-adder carry/borrow out.
REQ-011 SHALL have port acc_mode  input  1  1 = result continues an accumulation, 0 = starts a new one.
REQ-012 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-013 SHALL have port p  output  48  result.
REQ-014 SHALL have port pcout  output  48  cascade copy of p.
REQ-015 SHALL have port p_fb  output  48  feedback to Z-mux; always the internal P register, regardless of PREG.
REQ-016 SHALL have port carryout  output  1  carry result.
REQ-017 SHALL have port carryoutf  output  1  fabric copy of carryout.
REQ-018 SHALL have port out_valid  output  1  p holds a newly captured result.
REQ-019 SHALL have port acc_cnt  output  16  results in the current accumulation run.
REQ-020 SHALL have port ovf_sticky  output  1  carry/borrow seen since last clear.

Function
REQ-021 Capture event = in_valid & cep on a rising clk edge with rstp=0.
REQ-022 The P register SHALL load post_out on a capture event and hold otherwise; with cep=0 nothing changes, including p_fb.
REQ-023 With PREG=1: p = P register; out_valid SHALL be 1 for exactly the cycle after each capture event (1-cycle latency), 0 otherwise.
REQ-024 With PREG=0: p = post_out combinationally and out_valid = in_valid & cep.
REQ-025 pcout SHALL equal p at all times; carryoutf SHALL equal carryout at all times.
REQ-026 The carry register SHALL load post_cout on every edge with cecarry=1, independent of in_valid.
REQ-027 carryout SHALL equal the carry register when CARRYOUTREG=1 and post_cout when CARRYOUTREG=0.
REQ-028 On a capture event with acc_mode=0, acc_cnt SHALL load 1.
REQ-029 On a capture event with acc_mode=1, acc_cnt SHALL increment by 1, saturating at 16'hFFFF (no wrap).
REQ-030 acc_cnt SHALL hold when no capture event occurs.
REQ-031 ovf_sticky SHALL set on a capture event with post_cout=1.
REQ-032 ovf_sticky SHALL clear on ovf_clr=1 when not setting.
REQ-033 A simultaneous set and ovf_clr SHALL leave ovf_sticky at 1 (set wins).
REQ-034 ovf_sticky SHALL be unaffected by cecarry and by CARRYOUTREG.
REQ-035 rstp=1 SHALL clear the P register, carry register, out_valid and acc_cnt on the next edge, taking priority over cep and cecarry.
REQ-036 rstp SHALL NOT clear ovf_sticky.
REQ-037 Priority SHALL be: rst_n, then rstp, then ovf set, then ovf_clr, then capture and hold.

Reset
REQ-038 rst_n=0 SHALL immediately, without a clock edge, force the P register=0, carry register=0, out_valid=0, acc_cnt=0 and ovf_sticky=0, so that p=pcout=p_fb=0 and carryout=carryoutf=0 when PREG=1 and CARRYOUTREG=1.
REQ-039 rst_n asserted mid-accumulation SHALL discard the run; the first capture after release SHALL load acc_cnt=1 if acc_mode=0, or 1 if acc_mode=1 (0+1).
REQ-040 Outputs SHALL be stable and all-zero throughout reset.
REQ-041 Deassertion of rst_n SHALL take effect at the first clk edge after release.

Verification
REQ-042 PREG=1: capture post_out=48'h0000_0000_1234 with acc_mode=0 -> next cycle p=pcout=p_fb=48'h1234, out_valid=1 for one cycle, acc_cnt=1.
REQ-043 Three consecutive captures with acc_mode=1 after a start, with cep=0 on the middle cycle -> acc_cnt sequence 1,2,2,3; p holds during cep=0; no out_valid that cycle.
REQ-044 Preload acc_cnt=16'hFFFE, then three acc_mode=1 captures -> acc_cnt 16'hFFFF, 16'hFFFF, 16'hFFFF.
REQ-045 Capture with post_cout=1 while ovf_clr=1 -> ovf_sticky=1; next cycle ovf_clr=1 with no capture -> ovf_sticky=0; rstp pulse does not clear it.
REQ-046 cecarry=1 with in_valid=0 and post_cout=1 -> carryout=carryoutf=1 next cycle (CARRYOUTREG=1); CARRYOUTREG=0 -> carryout follows post_cout in the same cycle.
REQ-047 rst_n pulled low between edges during a run with acc_cnt=5 -> p, acc_cnt, out_valid and ovf_sticky read 0 before the next edge.

Source files
------------

// File: rtl/p_output_stage.sv
// P output stage: result/carry registers, valid flag, accumulation
// run counter and sticky overflow, with PREG/CARRYOUTREG bypass.
module p_output_stage #(
  parameter bit PREG        = 1'b1,
  parameter bit CARRYOUTREG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rstp,
  input  logic        cep,
  input  logic        cecarry,
  input  logic        in_valid,
  input  logic [47:0] post_out,
  input  logic        post_cout,
  input  logic        acc_mode,
  input  logic        ovf_clr,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic [47:0] p_fb,
  output logic        carryout,
  output logic        carryoutf,
  output logic        out_valid,
  output logic [15:0] acc_cnt,
  output logic        ovf_sticky
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [47:0] p_reg;
  logic        carry_reg;
  logic        vld_reg;
  logic [15:0] cnt_reg;
  logic        ovf_reg;

  logic        capture;
  logic        ovf_set;
  logic [15:0] cnt_next;

  assign capture = in_valid & cep & ~rstp;
  assign ovf_set = capture & post_cout;

  always_comb begin
    cnt_next = cnt_reg;
    if (!acc_mode)
      cnt_next = 16'd1;
    else if (cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg   <= '0;
      vld_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (rstp) begin
      p_reg   <= '0;
      vld_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      vld_reg <= capture;
      if (capture) begin
        p_reg   <= post_out;
        cnt_reg <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      carry_reg <= 1'b0;
    else if (rstp)
      carry_reg <= 1'b0;
    else if (cecarry)
      carry_reg <= post_cout;
  end

  // Sticky flag ignores rstp; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (ovf_set)
      ovf_reg <= 1'b1;
    else if (ovf_clr)
      ovf_reg <= 1'b0;
  end

  assign p          = PREG ? p_reg : post_out;
  assign out_valid  = PREG ? vld_reg : (in_valid & cep);
  assign pcout      = p;
  assign p_fb       = p_reg;
  assign carryout   = CARRYOUTREG ? carry_reg : post_cout;
  assign carryoutf  = carryout;
  assign acc_cnt    = cnt_reg;
  assign ovf_sticky = ovf_reg;

endmodule
